// File: rtl/viterbi_decoder_k3_if.sv
// rtl/viterbi_decoder_k3_if.sv - symbol-in / decoded-word-out handshake bundle for the K=3 Viterbi decoder
interface viterbi_decoder_k3_if #(
   parameter int DATA_W = 8,
   parameter int PM_W   = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_sym;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [PM_W-1:0]   out_err;

   modport master (
      output in_valid, in_sym, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_sym, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/viterbi_decoder_k3.sv
// rtl/viterbi_decoder_k3.sv - hard-decision Viterbi decoder, rate 1/2, K=3, G=(7,5) octal
module viterbi_decoder_k3 #(
   parameter int DATA_W = 8,
   parameter int PM_W   = 5
) (
   input logic            clk,
   input logic            reset,
   viterbi_decoder_k3_if.slave bus
);
   localparam int FRAME = DATA_W + 2;
   localparam int CNT_W = $clog2(DATA_W + 3);
   localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(DATA_W + 1);
   localparam logic [CNT_W-1:0] TB_INIT  = CNT_W'(DATA_W + 2);
   localparam logic [PM_W-1:0]  PM_MAX   = '1;

   typedef enum logic [1:0] {ACC, TB, OUT} state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  sym_cnt, tb_cnt;
   logic [1:0]        tb_state;
   logic [PM_W-1:0]   pm [4];
   logic [PM_W-1:0]   pm_new [4];
   logic [3:0]        dec_new;
   logic [3:0]        dec_mem [FRAME];
   logic [3:0]        dec_rd;
   logic [DATA_W-1:0] data_q;
   logic [PM_W-1:0]   err_q;
   logic              in_ready, out_valid, accept, last_sym;

   function automatic logic [1:0] branch_metric(input logic [1:0] exp_sym, input logic [1:0] sym);
      logic [1:0] d;
      d = exp_sym ^ sym;
      return {1'b0, d[1]} + {1'b0, d[0]};
   endfunction

   function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
      logic [PM_W:0] s;
      s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
      return s[PM_W] ? PM_MAX : s[PM_W-1:0];
   endfunction

   // New state {a,u} is reached from {0,a} or {1,a}; ties keep the s1=0 predecessor.
   for (genvar ns = 0; ns < 4; ns++) begin : g_acs
      localparam logic A = 1'(ns >> 1);
      localparam logic U = 1'(ns);
      localparam logic [1:0] P0 = {1'b0, A};
      localparam logic [1:0] P1 = {1'b1, A};
      localparam logic [1:0] E0 = {U ^ A, U};
      localparam logic [1:0] E1 = {~(U ^ A), ~U};
      logic [PM_W-1:0] c0, c1;
      assign c0          = sat_add(pm[P0], branch_metric(E0, bus.in_sym));
      assign c1          = sat_add(pm[P1], branch_metric(E1, bus.in_sym));
      assign dec_new[ns] = (c1 < c0);
      assign pm_new[ns]  = (c1 < c0) ? c1 : c0;
   end

   assign accept        = bus.in_valid && (state == ACC);
   assign last_sym      = (sym_cnt == LAST_SYM);
   assign dec_rd        = dec_mem[tb_cnt];
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = data_q;
   assign bus.out_err   = err_q;

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ACC: begin
            in_ready = 1'b1;
            if (bus.in_valid && last_sym) state_next = TB;
         end
         TB:  if (tb_cnt == '0) state_next = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_next = ACC;
         end
         default: state_next = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) dec_mem[sym_cnt] <= dec_new;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ACC;
         sym_cnt  <= '0;
         tb_cnt   <= '0;
         tb_state <= '0;
         pm[0]    <= '0;
         pm[1]    <= PM_MAX;
         pm[2]    <= PM_MAX;
         pm[3]    <= PM_MAX;
         data_q   <= '0;
         err_q    <= '0;
      end else begin
         state <= state_next;
         case (state)
            ACC: begin
               tb_cnt <= TB_INIT;
               if (accept) begin
                  for (int i = 0; i < 4; i++) pm[i] <= pm_new[i];
                  sym_cnt <= last_sym ? '0 : sym_cnt + 1'b1;
               end
            end
            TB: begin
               tb_cnt <= tb_cnt - 1'b1;
               // First TB cycle only captures the final metric; steps t=DATA_W+1..0 follow.
               if (tb_cnt == TB_INIT) begin
                  err_q    <= pm[0];
                  tb_state <= '0;
               end else begin
                  tb_state <= {dec_rd[tb_state], tb_state[1]};
                  for (int i = 0; i < DATA_W; i++)
                     if (tb_cnt == CNT_W'(i)) data_q[i] <= tb_state[0];
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  sym_cnt <= '0;
                  pm[0]   <= '0;
                  pm[1]   <= PM_MAX;
                  pm[2]   <= PM_MAX;
                  pm[3]   <= PM_MAX;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// tb/tb_viterbi_decoder_k3.sv - scoreboard bench for viterbi_decoder_k3
module tb_viterbi_decoder_k3;
   localparam int DATA_W = 8;
   localparam int PM_W   = 5;
   localparam int FRAME  = DATA_W + 2;
   localparam int LAT    = DATA_W + 3;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [PM_W-1:0]   err;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_acc = 0;
   exp_t sb[$];
   logic [1:0] syms [FRAME];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   viterbi_decoder_k3_if #(.DATA_W(DATA_W), .PM_W(PM_W)) bus ();

   viterbi_decoder_k3 #(.DATA_W(DATA_W), .PM_W(PM_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic build(input logic [DATA_W-1:0] info);
      logic s0, s1, u;
      s0 = 1'b0;
      s1 = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         u = (i < DATA_W) ? info[i] : 1'b0;
         syms[i] = {u ^ s0 ^ s1, u ^ s1};
         s1 = s0;
         s0 = u;
      end
   endtask

   task automatic flip(input int b);
      syms[b/2][b%2] = ~syms[b/2][b%2];
   endtask

   task automatic push_exp(input logic [DATA_W-1:0] data, input int err);
      exp_t e;
      e.data = data;
      e.err  = PM_W'(err);
      sb.push_back(e);
   endtask

   task automatic send_sym(input logic [1:0] s);
      logic rdy;
      int   guard;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.in_sym   = s;
      do begin
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!rdy && guard < 50);
      if (!rdy) check_eq("in_ready_wait", 32'(rdy), 1);
      last_acc = cyc;
   endtask

   task automatic drive_frame(input int n, input logic [31:0] gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps[i]) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         send_sym(syms[i]);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic receive(input bit lat, input int hold, input bit present);
      exp_t e;
      int   guard;
      guard = 0;
      while (bus.out_valid !== 1'b1 && guard < 4*LAT) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check_eq("out_valid_seen", 32'(bus.out_valid), 1);
      if (bus.out_valid !== 1'b1) return;
      if (lat) check_eq("latency", cyc - last_acc, LAT);
      check_eq("sb_level", 32'(sb.size() > 0), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check_eq("out_data", 32'(bus.out_data), 32'(e.data));
      check_eq("out_err", 32'(bus.out_err), 32'(e.err));
      if (present) begin
         bus.in_valid = 1'b1;
         bus.in_sym   = syms[0];
      end
      repeat (hold) begin
         @(posedge clk);
         #1;
         check_eq("hold_valid", 32'(bus.out_valid), 1);
         check_eq("hold_in_ready", 32'(bus.in_ready), 0);
         check_eq("hold_data", 32'(bus.out_data), 32'(e.data));
         check_eq("hold_err", 32'(bus.out_err), 32'(e.err));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check_eq("release_valid", 32'(bus.out_valid), 0);
      check_eq("release_in_ready", 32'(bus.in_ready), 1);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 1);
      check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      check_eq({tag, "_out_data"}, 32'(bus.out_data), 0);
      check_eq({tag, "_out_err"}, 32'(bus.out_err), 0);
   endtask

   task automatic pulse_reset(input string tag);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_vals(tag);
   endtask

   initial begin
      logic [DATA_W-1:0] info;
      logic [31:0]       gaps;
      int                n, b1, b2, ng;

      bus.in_valid  = 1'b0;
      bus.in_sym    = 2'b00;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("por");
      reset = 1'b0;

      build(8'h01);
      push_exp(8'h01, 0);
      drive_frame(FRAME, 0);
      receive(1, 0, 0);

      build(8'h01);
      syms[1] = 2'b00;
      push_exp(8'h01, 1);
      drive_frame(FRAME, 0);
      receive(1, 0, 0);

      build(8'h00);
      push_exp(8'h00, 0);
      drive_frame(FRAME, 0);
      receive(1, 0, 0);

      build(8'hFF);
      push_exp(8'hFF, 0);
      drive_frame(FRAME, 0);
      receive(1, 0, 0);

      build(8'h3C);
      push_exp(8'h3C, 0);
      drive_frame(FRAME, 0);
      build(8'hC3);
      push_exp(8'hC3, 0);
      receive(1, 5, 1);
      drive_frame(FRAME, 0);
      receive(1, 0, 0);

      build(8'h01);
      push_exp(8'h01, 0);
      gaps = '0;
      ng = 0;
      while (ng < 3) begin
         n = $urandom_range(1, FRAME-1);
         if (!gaps[n]) begin
            gaps[n] = 1'b1;
            ng++;
         end
      end
      drive_frame(FRAME, gaps);
      receive(1, 0, 0);

      // Two or fewer channel errors are always within the code's correcting power.
      for (int r = 0; r < 6; r++) begin
         info = DATA_W'($urandom);
         n = r % 3;
         build(info);
         b1 = $urandom_range(0, 2*FRAME-1);
         b2 = (b1 + $urandom_range(1, 2*FRAME-1)) % (2*FRAME);
         if (n >= 1) flip(b1);
         if (n >= 2) flip(b2);
         push_exp(info, n);
         drive_frame(FRAME, 0);
         receive(1, 0, 0);
      end

      build(8'h5A);
      drive_frame(4, 0);
      pulse_reset("rst_acc");
      build(8'hA5);
      push_exp(8'hA5, 0);
      drive_frame(FRAME, 0);
      receive(1, 0, 0);

      build(8'h77);
      drive_frame(FRAME, 0);
      repeat (4) @(posedge clk);
      #1;
      pulse_reset("rst_tb");
      build(8'hA5);
      push_exp(8'hA5, 0);
      drive_frame(FRAME, 0);
      receive(1, 0, 0);

      check_eq("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/viterbi_decoder_k3.md
Name: viterbi_decoder_k3

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, constraint-length-3 convolutional code.
- Generators: G0 = 7 octal, G1 = 5 octal.
- Sits directly downstream of the convolutional encoder and channel. It consumes one 2-bit coded symbol per accepted cycle.
- Each frame is DATA_W info bits plus 2 zero tail bits. After the frame, the block runs traceback from state 0 and presents the decoded word with its path metric (corrected-bit count).

Parameters:
- DATA_W, 8, info bits per frame. Frame = DATA_W+2 symbols.
- PM_W, 5, path-metric width. Must hold 2*(DATA_W+2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_sym is valid this cycle.
- in_ready  out  1  block accepts a symbol this cycle.
- in_sym  in  2  coded symbol. [1] = u^s0^s1 (G0), [0] = u^s1 (G1).
- out_valid  out  1  out_data/out_err are valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  decoded bits. First info bit received goes in bit 0.
- out_err  out  PM_W  final metric of state 00 = Hamming distance to the ML codeword.

Behaviour:
- One clock (clk). Reset is synchronous and active-high. It overrides all other activity, including mid-frame and mid-traceback.
- Reset values:
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_err=0.
  - Internal: symbol counter=0; PM[00]=0, PM[01]=PM[10]=PM[11]=all-ones; survivor memory contents don't-care.
- Trellis:
  - State S={s1,s0}. s0 = previous input, s1 = the input before it.
  - Input u moves S to {s0,u}.
  - Predecessors of {a,u} are {0,a} and {1,a}.
- ACS (one per accepted symbol, i.e. in_valid & in_ready):
  - Branch metric = popcount(expected symbol XOR in_sym), range 0..2.
  - Candidate = PM[pred] + BM, saturating at 2^PM_W-1.
  - New PM = min of the two candidates.
  - Decision bit = s1 of the winning predecessor. On a tie, choose predecessor s1=0.
  - Store 4 decision bits per step at address = symbol index (0..DATA_W+1).
- FSM states:
  - ACC: in_ready=1. Each accept increments the symbol counter. The accept of symbol DATA_W+1 moves to TB on the next edge.
  - TB: in_ready=0. One step per cycle for DATA_W+2 cycles, t = DATA_W+1 down to 0.
    - Start state 00.
    - Decoded bit = LSB of current state.
    - Previous state = {decision[t][state], MSB of current state}.
    - For t<DATA_W, write the bit to out_data[t]. Tail bits are discarded.
    - out_err latches PM[00] on entry to TB.
  - OUT: out_valid=1, in_ready=0. out_data/out_err are held stable until out_valid & out_ready. Then go to ACC, clear counter/PMs to reset values, and deassert out_valid.
- Latency: out_valid rises exactly DATA_W+3 cycles after the edge accepting the last tail symbol (2+DATA_W+1).
- No accept occurs while in TB/OUT. Symbols presented then stall; in_valid is not required to drop.
- in_valid low in ACC: no ACS, PMs hold.
- Unterminated frames (non-zero tail) still trace back from 00. Output is then whatever the survivor path gives; no error flag.

Test Plan:
- Clean frame, DATA_W=8, info 0x01 (u0=1, rest 0): symbols 11,10,11,00×7 -> out_data=0x01, out_err=0. out_valid exactly 11 cycles after the last accept.
- Single bit error: same frame with symbol 1 corrupted 10->00 -> out_data=0x01, out_err=1.
- All-zero frame: 10×00 -> out_data=0x00, out_err=0. Then all-ones info (0xFF) encoded cleanly -> out_data=0xFF, out_err=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid. out_data/out_err are stable and in_ready=0 throughout.
  - Assert out_ready: out_valid drops next cycle, in_ready=1.
  - Back-to-back next frame decodes correctly.
- Input gaps: the 0x01 frame with in_valid low for 3 random cycles between symbols -> identical result, latency counted from the last accept.
- Reset mid-operation: reset after 4 symbols accepted, and separately during TB -> outputs at reset values next cycle. A following clean 0xA5 frame decodes to 0xA5, out_err=0.
